// File: rtl/fifo_line_reader_pkg.sv
// Shared types for the line reader: FSM state encoding and the output-buffer entry.
package fifo_line_reader_pkg;

    // Pixel width carried by a buffer entry; the reader's DATA_WIDTH is expected to match.
    localparam int PIX_W = 8;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_FILL = 2'd1,
        LINE      = 2'd2,
        DRAIN     = 2'd3
    } state_t;

    // One pixel plus its framing tags, as stored in the output buffer.
    typedef struct packed {
        logic [PIX_W-1:0] data;
        logic             sof;
        logic             eol;
    } buf_entry_t;

endpackage

// File: rtl/fifo_out_buf2.sv
// Two-entry valid/ready output buffer. The head entry is held stable until popped.
module fifo_out_buf2
    import fifo_line_reader_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       push,
    input  buf_entry_t push_entry,
    input  logic       pop,
    output buf_entry_t head,
    output logic       valid,
    output logic [1:0] occ
);

    buf_entry_t mem [2];
    logic       wr_ptr;
    logic       rd_ptr;
    logic [1:0] occ_q;

    // Storage, pointers and occupancy; push and pop may happen in the same cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem[0] <= '0;
            mem[1] <= '0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            occ_q  <= 2'd0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= push_entry;
                wr_ptr      <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            case ({push, pop})
                2'b10:   occ_q <= occ_q + 2'd1;
                2'b01:   occ_q <= occ_q - 2'd1;
                default: occ_q <= occ_q;
            endcase
        end
    end

    assign head  = mem[rd_ptr];
    assign valid = (occ_q != 2'd0);
    assign occ   = occ_q;

endmodule

// File: rtl/fifo_line_reader.sv
// Read-side sequencer for the pixel async FIFO: drains whole lines, frames them with
// sof/eol, and flags FIFO underruns.
//
// Handshake: a beat transfers when m_valid && m_ready are both high on a rising rd_clk;
// while m_valid && !m_ready, m_data/m_sof/m_eol hold their values and m_valid stays high.
module fifo_line_reader
    import fifo_line_reader_pkg::*;
#(
    parameter int DATA_WIDTH    = PIX_W,
    parameter int H_WIDTH       = 12,
    parameter int V_WIDTH       = 12,
    parameter int STALL_TIMEOUT = 1023
) (
    input  logic                  rd_clk,
    input  logic                  rd_rst_n,
    input  logic                  cfg_enable,
    input  logic [H_WIDTH-1:0]    cfg_h_active,
    input  logic [V_WIDTH-1:0]    cfg_v_active,
    output logic                  fifo_rd_en,
    input  logic [DATA_WIDTH-1:0] fifo_rd_data,
    input  logic                  fifo_rd_empty,
    input  logic                  fifo_almost_empty,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic                  m_sof,
    output logic                  m_eol,
    output logic                  busy,
    output logic [V_WIDTH-1:0]    line_cnt,
    output logic                  frame_done,
    output logic                  underrun,
    output state_t                dbg_state
);

    localparam int STALL_W = $clog2(STALL_TIMEOUT + 1);

    state_t               state_q;
    logic [H_WIDTH-1:0]   h_lat;
    logic [V_WIDTH-1:0]   v_lat;
    logic [H_WIDTH-1:0]   px_left;
    logic [V_WIDTH-1:0]   line_q;
    logic [STALL_W-1:0]   stall_cnt;
    logic                 underrun_q;
    logic                 frame_done_q;

    logic                 inflight_q;
    logic                 inflight_sof_q;
    logic                 inflight_eol_q;

    buf_entry_t           push_entry;
    buf_entry_t           head;
    logic                 buf_valid;
    logic [1:0]           occ;

    logic                 pop;
    logic [2:0]           pending;
    logic                 rd_fire;
    logic                 rd_sof;
    logic                 rd_eol;
    logic                 last_line;
    logic                 cfg_ok;
    logic                 drain_done;

    assign pop       = buf_valid && m_ready;
    // Words resident plus the one in flight; a read is allowed only if that stays <= 2.
    assign pending   = {1'b0, occ} + {2'b00, inflight_q};
    assign rd_fire   = (state_q == LINE) && !fifo_rd_empty && (px_left != '0) &&
                       (pending < (3'd2 + {2'b00, pop}));
    assign rd_sof    = (line_q == '0) && (px_left == h_lat);
    assign rd_eol    = (px_left == H_WIDTH'(1));
    assign last_line = (line_q == (v_lat - V_WIDTH'(1)));
    assign cfg_ok    = cfg_enable && (cfg_h_active != '0) && (cfg_v_active != '0);
    // The frame is finished once nothing is in flight and the buffer empties this cycle,
    // so frame_done lands in the cycle right after the final accepted beat.
    assign drain_done = !inflight_q && ((occ == 2'd0) || ((occ == 2'd1) && pop));

    // Track the read issued last cycle so its returning word is pushed with its tags.
    always_ff @(posedge rd_clk or negedge rd_rst_n) begin
        if (!rd_rst_n) begin
            inflight_q     <= 1'b0;
            inflight_sof_q <= 1'b0;
            inflight_eol_q <= 1'b0;
        end else begin
            inflight_q     <= rd_fire;
            inflight_sof_q <= rd_fire && rd_sof;
            inflight_eol_q <= rd_fire && rd_eol;
        end
    end

    // Frame/line sequencer with pixel, line and stall counters.
    always_ff @(posedge rd_clk or negedge rd_rst_n) begin
        if (!rd_rst_n) begin
            state_q      <= IDLE;
            h_lat        <= '0;
            v_lat        <= '0;
            px_left      <= '0;
            line_q       <= '0;
            stall_cnt    <= '0;
            underrun_q   <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            frame_done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    stall_cnt <= '0;
                    if (cfg_ok) begin
                        h_lat      <= cfg_h_active;
                        v_lat      <= cfg_v_active;
                        line_q     <= '0;
                        underrun_q <= 1'b0;
                        state_q    <= WAIT_FILL;
                    end
                end
                WAIT_FILL: begin
                    stall_cnt <= '0;
                    if (!fifo_almost_empty) begin
                        px_left <= h_lat;
                        state_q <= LINE;
                    end
                end
                LINE: begin
                    if ((px_left != '0) && fifo_rd_empty) begin
                        if (stall_cnt == STALL_W'(STALL_TIMEOUT - 1)) begin
                            underrun_q <= 1'b1;
                        end else begin
                            stall_cnt <= stall_cnt + STALL_W'(1);
                        end
                    end else begin
                        stall_cnt <= '0;
                    end
                    if (rd_fire) begin
                        px_left <= px_left - H_WIDTH'(1);
                        if (rd_eol) begin
                            if (last_line) begin
                                state_q <= DRAIN;
                            end else begin
                                line_q  <= line_q + V_WIDTH'(1);
                                state_q <= WAIT_FILL;
                            end
                        end
                    end
                end
                DRAIN: begin
                    stall_cnt <= '0;
                    if (drain_done) begin
                        frame_done_q <= 1'b1;
                        if (cfg_ok) begin
                            h_lat      <= cfg_h_active;
                            v_lat      <= cfg_v_active;
                            line_q     <= '0;
                            underrun_q <= 1'b0;
                            state_q    <= WAIT_FILL;
                        end else begin
                            state_q <= IDLE;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign push_entry.data = PIX_W'(fifo_rd_data);
    assign push_entry.sof  = inflight_sof_q;
    assign push_entry.eol  = inflight_eol_q;

    fifo_out_buf2 u_out_buf (
        .clk        (rd_clk),
        .rst_n      (rd_rst_n),
        .push       (inflight_q),
        .push_entry (push_entry),
        .pop        (pop),
        .head       (head),
        .valid      (buf_valid),
        .occ        (occ)
    );

    assign fifo_rd_en = rd_fire;
    assign m_data     = DATA_WIDTH'(head.data);
    assign m_sof      = head.sof;
    assign m_eol      = head.eol;
    assign m_valid    = buf_valid;
    assign busy       = (state_q != IDLE);
    assign line_cnt   = line_q;
    assign frame_done = frame_done_q;
    assign underrun   = underrun_q;
    assign dbg_state  = state_q;

endmodule

// File: tb/tb_fifo_line_reader.sv
`timescale 1ns/1ps
module tb_fifo_line_reader;
  import fifo_line_reader_pkg::*;

  localparam int DW = 8;
  localparam int HW = 12;
  localparam int VW = 12;
  localparam int ST = 15;

  // ---------------- clock / reset / DUT ----------------
  logic          rd_clk = 1'b0;
  logic          rd_rst_n = 1'b0;
  logic          cfg_enable = 1'b0;
  logic [HW-1:0] cfg_h_active = '0;
  logic [VW-1:0] cfg_v_active = '0;
  logic          fifo_rd_en;
  logic [DW-1:0] fifo_rd_data = '0;
  logic          fifo_rd_empty;
  logic          fifo_almost_empty;
  logic [DW-1:0] m_data;
  logic          m_valid;
  logic          m_ready = 1'b0;
  logic          m_sof;
  logic          m_eol;
  logic          busy;
  logic [VW-1:0] line_cnt;
  logic          frame_done;
  logic          underrun;
  state_t        dbg_state;

  always #5 rd_clk = ~rd_clk;

  fifo_line_reader #(
    .DATA_WIDTH(DW), .H_WIDTH(HW), .V_WIDTH(VW), .STALL_TIMEOUT(ST)
  ) dut (
    .rd_clk(rd_clk), .rd_rst_n(rd_rst_n), .cfg_enable(cfg_enable),
    .cfg_h_active(cfg_h_active), .cfg_v_active(cfg_v_active),
    .fifo_rd_en(fifo_rd_en), .fifo_rd_data(fifo_rd_data),
    .fifo_rd_empty(fifo_rd_empty), .fifo_almost_empty(fifo_almost_empty),
    .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready), .m_sof(m_sof), .m_eol(m_eol),
    .busy(busy), .line_cnt(line_cnt), .frame_done(frame_done), .underrun(underrun),
    .dbg_state(dbg_state)
  );

  // ---------------- FIFO model and scoreboard state ----------------
  int            total = 0;
  int            bad = 0;
  logic [DW-1:0] fifo_q[$];
  int            fifo_cnt = 0;
  logic          ae_force = 1'b0;
  logic          rd_take = 1'b0;
  logic [DW+1:0] exp_q[$];
  int            cyc = 0;
  int            beat_cnt = 0;
  int            last_beat_cyc = 0;
  int            fd_cnt = 0;
  int            outstanding = 0;
  logic          prev_stall = 1'b0;
  logic [DW+1:0] prev_word = '0;

  assign fifo_rd_empty     = (fifo_cnt == 0);
  assign fifo_almost_empty = ae_force || (fifo_cnt == 0);

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // FIFO read port: read data appears the cycle after the sampled read enable.
  always @(posedge rd_clk) begin
    if (rd_take) begin
      fifo_rd_data <= fifo_q.pop_front();
      fifo_cnt     <= fifo_cnt - 1;
    end
  end

  // Output monitor: scoreboard pops, hold rule, read-enable bounds, frame_done timing.
  always @(negedge rd_clk) begin : mon
    logic          beat;
    logic [DW+1:0] e;
    cyc++;
    if (!rd_rst_n) begin
      outstanding = 0;
      prev_stall  = 1'b0;
      rd_take     = 1'b0;
    end else begin
      beat = m_valid && m_ready;
      if (prev_stall) check("hold", 32'({m_valid, m_sof, m_eol, m_data}), 32'({1'b1, prev_word}));
      if (beat) begin
        if (exp_q.size() == 0) begin
          check("extra_beat", 32'(exp_q.size()), 32'd1);
        end else begin
          e = exp_q.pop_front();
          check("beat", 32'({m_sof, m_eol, m_data}), 32'(e));
        end
        beat_cnt++;
        last_beat_cyc = cyc;
      end
      if (frame_done) begin
        check("frame_done_lat", 32'(cyc - last_beat_cyc), 32'd1);
        fd_cnt++;
      end
      rd_take = fifo_rd_en && (fifo_cnt > 0);
      if (fifo_rd_en) check("rd_en_nonempty", 32'(fifo_cnt != 0), 32'd1);
      outstanding = outstanding + (fifo_rd_en ? 1 : 0) - (beat ? 1 : 0);
      if (fifo_rd_en) check("outstanding_le2", 32'(outstanding <= 2), 32'd1);
      prev_stall = m_valid && !m_ready;
      prev_word  = {m_sof, m_eol, m_data};
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge rd_clk);
    #1;
  endtask

  task automatic push_word(input logic [DW-1:0] d, input logic sof, input logic eol);
    fifo_q.push_back(d);
    fifo_cnt = fifo_cnt + 1;
    exp_q.push_back({sof, eol, d});
  endtask

  task automatic push_frame(input int h, input int v);
    for (int l = 0; l < v; l++)
      for (int p = 0; p < h; p++)
        push_word(DW'($urandom_range(0, 255)), (l == 0) && (p == 0), p == h - 1);
  endtask

  task automatic wait_fd(input int target, input int bound);
    int n;
    n = 0;
    while (fd_cnt < target && n < bound) begin
      tick();
      n++;
    end
    check("frame_done_count", 32'(fd_cnt), 32'(target));
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_m_valid"}, 32'(m_valid), 32'd0);
    check({tag, "_m_data"}, 32'(m_data), 32'd0);
    check({tag, "_m_sof_eol"}, 32'({m_sof, m_eol}), 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_line_cnt"}, 32'(line_cnt), 32'd0);
    check({tag, "_frame_done"}, 32'(frame_done), 32'd0);
    check({tag, "_underrun"}, 32'(underrun), 32'd0);
    check({tag, "_rd_en"}, 32'(fifo_rd_en), 32'd0);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int n;
    int b0;
    int ae_rd;

    repeat (3) tick();
    check_all_zero("in_reset");
    rd_rst_n = 1'b1;
    @(negedge rd_clk);
    check_all_zero("after_reset");
    check("reset_state", 32'(dbg_state), 32'(IDLE));

    // Frame h=4 v=2, preloaded, m_ready high; enable dropped during line 0.
    tick();
    cfg_h_active = 12'd4;
    cfg_v_active = 12'd2;
    push_frame(4, 2);
    m_ready    = 1'b1;
    cfg_enable = 1'b1;
    n = 0;
    do begin
      @(negedge rd_clk);
      n++;
    end while (!fifo_rd_en && n < 20);
    check("first_rd_en", 32'(fifo_rd_en), 32'd1);
    @(negedge rd_clk);
    check("latency_n1", 32'(m_valid), 32'd0);
    @(negedge rd_clk);
    check("latency_n2", 32'(m_valid), 32'd1);
    check("first_sof", 32'(m_sof), 32'd1);
    tick();
    cfg_enable = 1'b0;
    wait_fd(1, 100);
    tick();
    check("busy_after_frame1", 32'(busy), 32'd0);
    check("beats_frame1", 32'(beat_cnt), 32'd8);
    check("sb_empty1", 32'(exp_q.size()), 32'd0);

    // Same config with m_ready toggling.
    tick();
    push_frame(4, 2);
    cfg_enable = 1'b1;
    for (int i = 0; i < 200 && fd_cnt < 2; i++) begin
      tick();
      m_ready = i[0];
      if (i == 6) cfg_enable = 1'b0;
    end
    m_ready = 1'b1;
    check("frame_done_toggle", 32'(fd_cnt), 32'd2);
    check("beats_frame2", 32'(beat_cnt), 32'd16);
    check("sb_empty2", 32'(exp_q.size()), 32'd0);

    // Almost-empty held high keeps the reader in WAIT_FILL.
    tick();
    ae_force     = 1'b1;
    cfg_v_active = 12'd1;
    push_frame(4, 1);
    cfg_enable = 1'b1;
    ae_rd = 0;
    repeat (20) begin
      @(negedge rd_clk);
      if (fifo_rd_en) ae_rd++;
    end
    check("ae_no_rd", 32'(ae_rd), 32'd0);
    check("ae_state_wait", 32'(dbg_state), 32'(WAIT_FILL));
    tick();
    ae_force   = 1'b0;
    cfg_enable = 1'b0;
    @(negedge rd_clk);
    check("ae_release_state", 32'(dbg_state), 32'(WAIT_FILL));
    check("ae_release_rd", 32'(fifo_rd_en), 32'd0);
    @(negedge rd_clk);
    check("ae_line_state", 32'(dbg_state), 32'(LINE));
    check("ae_line_rd", 32'(fifo_rd_en), 32'd1);
    wait_fd(3, 100);

    // Underrun: FIFO runs dry after 2 of 4 pixels.
    tick();
    push_word(DW'($urandom_range(0, 255)), 1'b1, 1'b0);
    push_word(DW'($urandom_range(0, 255)), 1'b0, 1'b0);
    cfg_enable = 1'b1;
    n = 0;
    do begin
      @(negedge rd_clk);
      n++;
    end while (!(dbg_state == LINE && fifo_rd_empty) && n < 50);
    check("stall_seen", 32'(dbg_state == LINE && fifo_rd_empty), 32'd1);
    repeat (14) @(negedge rd_clk);
    check("underrun_before", 32'(underrun), 32'd0);
    @(negedge rd_clk);
    check("underrun_set", 32'(underrun), 32'd1);
    tick();
    cfg_enable = 1'b0;
    push_word(DW'($urandom_range(0, 255)), 1'b0, 1'b0);
    push_word(DW'($urandom_range(0, 255)), 1'b0, 1'b1);
    wait_fd(4, 100);
    tick();
    check("underrun_sticky", 32'(underrun), 32'd1);
    check("sb_empty4", 32'(exp_q.size()), 32'd0);

    // Zero-valued configuration never leaves IDLE.
    tick();
    cfg_h_active = 12'd0;
    cfg_v_active = 12'd2;
    cfg_enable   = 1'b1;
    repeat (5) tick();
    check("zero_h_busy", 32'(busy), 32'd0);
    check("zero_h_state", 32'(dbg_state), 32'(IDLE));
    cfg_h_active = 12'd4;
    cfg_v_active = 12'd0;
    repeat (5) tick();
    check("zero_v_busy", 32'(busy), 32'd0);
    cfg_enable = 1'b0;

    // Asynchronous reset mid-line.
    tick();
    cfg_v_active = 12'd2;
    push_frame(4, 2);
    m_ready    = 1'b0;
    cfg_enable = 1'b1;
    n = 0;
    do begin
      tick();
      n++;
    end while (!m_valid && n < 20);
    check("pre_reset_valid", 32'(m_valid), 32'd1);
    tick();
    tick();
    rd_rst_n   = 1'b0;
    cfg_enable = 1'b0;
    #1;
    check_all_zero("mid_reset");
    exp_q.delete();
    fifo_q.delete();
    fifo_cnt = 0;
    tick();
    tick();
    rd_rst_n = 1'b1;
    m_ready  = 1'b1;
    b0 = beat_cnt;
    repeat (20) tick();
    check("no_residual_beats", 32'(beat_cnt - b0), 32'd0);
    check("idle_after_reset", 32'(busy), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: run did not complete, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog expired");
  end

endmodule
